// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: default operand width and
// the controller state encoding used by div_unit.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left by one,
// bring in the next dividend bit, trial-subtract the divisor magnitude and
// keep the difference only when it does not underflow.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   partRem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             shiftIn_i,
  output logic [WIDTH:0]   partRem_o,
  output logic             quotBit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] divExt;

  // Shift, trial-subtract, restore when the divisor does not fit
  always_comb begin
    shifted   = (partRem_i << 1) | {{WIDTH{1'b0}}, shiftIn_i};
    divExt    = {1'b0, divisor_i};
    quotBit_o = (shifted >= divExt);
    partRem_o = quotBit_o ? (shifted - divExt) : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// Iterative MIPS-style DIV/DIVU unit: one restoring step per clock, WIDTH
// steps per division, results registered and held until the next done.
// Optional feature: define DIV_ZERO_FLAG_EN to add the div_zero output,
// which reports that the latched divisor was zero alongside q and r.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  divState_e        state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] qOut_q;
  logic [WIDTH-1:0] rOut_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             negQ_q;
  logic             negR_q;
  logic             zero_q;
`ifdef DIV_ZERO_FLAG_EN
  logic             divZero_q;
`endif

  logic [WIDTH:0]   remNext;
  logic             quotBit;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH-1:0] quotMag;
  logic [WIDTH-1:0] qFinal;
  logic [WIDTH-1:0] rFinal;

  div_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .partRem_i (rem_q),
    .divisor_i (dvs_q),
    .shiftIn_i (dvd_q[WIDTH-1]),
    .partRem_o (remNext),
    .quotBit_o (quotBit)
  );

  // Operand magnitudes at start, and sign/zero fix-up of the final step
  always_comb begin
    aMag    = (is_signed && a[WIDTH-1]) ? -a : a;
    bMag    = (is_signed && b[WIDTH-1]) ? -b : b;
    quotMag = {dvd_q[WIDTH-2:0], quotBit};
    rFinal  = negR_q ? -remNext[WIDTH-1:0] : remNext[WIDTH-1:0];
    qFinal  = zero_q ? '1 : (negQ_q ? -quotMag : quotMag);
  end

  // Controller and datapath registers; dvd_q shifts dividend bits out of
  // its top while quotient bits fill in from the bottom
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      qOut_q    <= '0;
      rOut_q    <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      zero_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      divZero_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= aMag;
            dvs_q   <= bMag;
            negQ_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            negR_q  <= is_signed & a[WIDTH-1];
            zero_q  <= (b == '0);
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rem_q <= remNext;
          dvd_q <= {dvd_q[WIDTH-2:0], quotBit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            qOut_q    <= qFinal;
            rOut_q    <= rFinal;
`ifdef DIV_ZERO_FLAG_EN
            divZero_q <= zero_q;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = qOut_q;
  assign r    = rOut_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero = divZero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results come from a behavioural
// division model, are queued when a division is started and are compared
// when the unit raises done.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W   = DIV_WIDTH;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } expect_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         isSigned;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
`ifdef DIV_ZERO_FLAG_EN
  logic         divZero;
`endif

  expect_t scoreboard[$];
  int vectorCount = 0;
  int missCount   = 0;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (isSigned),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero  (divZero)
`endif
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MIPS DIV/DIVU behaviour including the two corner cases
  function automatic expect_t modelDiv(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    expect_t e;
    e.dz = (y == '0);
    if (y == '0) begin
      e.q = '1;
      e.r = x;
    end else if (!s) begin
      e.q = x / y;
      e.r = x % y;
    end else if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin
      e.q = x;
      e.r = '0;
    end else begin
      e.q = $signed(x) / $signed(y);
      e.r = $signed(x) % $signed(y);
    end
    return e;
  endfunction

  // One comparison point
  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Walk cycles after a start until done rises; lat stays 0 on timeout
  task automatic waitForDone(input bit releaseStart, input bit scramble,
                             output int lat, output bit busyGood);
    lat = 0;
    busyGood = 1'b1;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(negedge clk);
      if (k == 1 && releaseStart) start = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busyGood = 1'b0;
      if (scramble) begin
        a = $urandom;
        b = $urandom;
        isSigned = ~isSigned;
      end
    end
  endtask

  // Pop the oldest expectation and compare it against the done-cycle outputs
  task automatic checkResult(input string tag);
    expect_t e;
    if (scoreboard.size() == 0) begin
      vectorCount++;
      missCount++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
      return;
    end
    e = scoreboard.pop_front();
    checkOutput({tag, "_q"}, q, e.q);
    checkOutput({tag, "_r"}, r, e.r);
    checkOutput({tag, "_busyAtDone"}, W'(busy), '0);
`ifdef DIV_ZERO_FLAG_EN
    checkOutput({tag, "_divZero"}, W'(divZero), W'(e.dz));
`endif
  endtask

  // Issue a single division, check latency, busy window, result and pulse
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic s, input string tag);
    int lat;
    bit busyGood;
    a = x;
    b = y;
    isSigned = s;
    start = 1'b1;
    scoreboard.push_back(modelDiv(x, y, s));
    waitForDone(1'b1, 1'b0, lat, busyGood);
    checkOutput({tag, "_latency"}, W'(lat), W'(LAT));
    checkOutput({tag, "_busyWindow"}, W'(busyGood), W'(1));
    checkResult(tag);
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, W'(done), '0);
  endtask

  initial begin
    int lat;
    bit busyGood;
    bit sawDone;
    bit sawBusy;

    rst = 1'b1;
    start = 1'b0;
    isSigned = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", W'(busy), '0);
    checkOutput("reset_done", W'(done), '0);
    checkOutput("reset_q", q, '0);
    checkOutput("reset_r", r, '0);
    rst = 1'b0;
    @(negedge clk);

    // Basic unsigned case, then check the result is held afterwards
    applyStimulus(32'd100, 32'd7, 1'b0, "divu_100_7");
    @(negedge clk);
    @(negedge clk);
    checkOutput("hold_q", q, 32'd14);
    checkOutput("hold_r", r, 32'd2);

    // Signed truncation toward zero and sign rules
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
    applyStimulus(-32'd100, -32'd7, 1'b1, "div_m100_m7");

    // Overflow and divide-by-zero corners
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_minneg_m1");
    applyStimulus(32'd5, 32'd0, 1'b0, "divu_5_0");
    applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, "div_m7_0");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_big_max");
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");

    // A few random operands in both modes
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom, W'($urandom_range(1, 1000)), i[0], "rand");
    end

    // start held through a run with changing operands; the second division
    // is accepted on the done cycle
    a = 32'd1000;
    b = 32'd33;
    isSigned = 1'b0;
    start = 1'b1;
    scoreboard.push_back(modelDiv(32'd1000, 32'd33, 1'b0));
    waitForDone(1'b0, 1'b1, lat, busyGood);
    checkOutput("b2b_first_latency", W'(lat), W'(LAT));
    checkOutput("b2b_first_busy", W'(busyGood), W'(1));
    checkResult("b2b_first");
    a = 32'hFFFF_FF00;
    b = 32'd3;
    isSigned = 1'b1;
    scoreboard.push_back(modelDiv(32'hFFFF_FF00, 32'd3, 1'b1));
    waitForDone(1'b1, 1'b0, lat, busyGood);
    checkOutput("b2b_second_latency", W'(lat), W'(LAT));
    checkOutput("b2b_second_busy", W'(busyGood), W'(1));
    checkResult("b2b_second");
    @(negedge clk);

    // Reset in the middle of a run discards it; start during reset ignored
    a = 32'd12345;
    b = 32'd11;
    isSigned = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 10; k++) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", W'(busy), '0);
    checkOutput("midrst_done", W'(done), '0);
    checkOutput("midrst_q", q, '0);
    checkOutput("midrst_r", r, '0);
`ifdef DIV_ZERO_FLAG_EN
    checkOutput("midrst_divZero", W'(divZero), '0);
`endif
    rst = 1'b0;
    start = 1'b0;
    sawDone = 1'b0;
    sawBusy = 1'b0;
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      if (done !== 1'b0) sawDone = 1'b1;
      if (busy !== 1'b0) sawBusy = 1'b1;
    end
    checkOutput("midrst_noDone", W'(sawDone), '0);
    checkOutput("midrst_noBusy", W'(sawBusy), '0);

    // Unit still works after the aborted run
    applyStimulus(32'd12345, 32'd11, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one division; sampled each cycle.
REQ-005 is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 a  input  WIDTH  dividend (rs), sampled with start.
REQ-007 b  input  WIDTH  divisor (rt), sampled with start.
REQ-008 busy  output  1  division in progress.
REQ-009 done  output  1  one-cycle pulse; q/r valid from this cycle.
REQ-010 q  output  WIDTH  quotient, feeds LO.
REQ-011 r  output  WIDTH  remainder, feeds HI.

Function
REQ-012 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE or DONE with start=1 -> RUN: latch a, b, is_signed; clear iteration counter; set busy next cycle.
REQ-014 start accepted in cycle N -> busy=1 in cycles N+1..N+WIDTH, done=1 only in cycle N+WIDTH+1, busy=0 then.
REQ-015 RUN: one restoring step per cycle (shift partial remainder left 1, trial-subtract |divisor|, set quotient bit); exactly WIDTH steps, then -> DONE.
REQ-016 DONE with start=0 -> IDLE next cycle; DONE with start=1 -> RUN (back-to-back, no bubble).
REQ-017 start while RUN ignored; latched operands unaffected.
REQ-018 Signed: divide magnitudes; q negated iff operand signs differ; r takes dividend's sign; truncation toward zero (MIPS DIV).
REQ-019 Unsigned: plain WIDTH-bit quotient and remainder.
REQ-020 b==0 (either mode): q = all ones, r = a; same latency as normal.
REQ-021 Signed a=most-negative, b=-1: q = most-negative, r = 0; no exception.
REQ-022 q/r change only in the done cycle; hold their value until the next done.
REQ-023 Partial remainder held in WIDTH+1 bits; no other internal widening.

Reset
REQ-024 rst=1 in any state, including mid-RUN: next cycle state=IDLE, busy=0, done=0, q=0, r=0, counter=0; in-flight division discarded.
REQ-025 start ignored in any cycle where rst=1.

Configuration
REQ-026 Macro DIV_ZERO_FLAG_EN defined: extra output div_zero (1 bit) equals (latched b==0) and is valid/held with q, r; reset 0.
REQ-027 Macro undefined: no div_zero port; all other behaviour identical.

Structure
REQ-028 Shared package holds WIDTH default constant and state enum typedef (IDLE, RUN, DONE).
REQ-029 One combinational sub-module div_step: one shift/trial-subtract iteration (partial remainder, divisor in; next remainder, quotient bit out).

Verification
REQ-030 DIVU a=100, b=7, start in cycle 0 -> done in cycle 33, q=14, r=2, busy high cycles 1..32.
REQ-031 DIV a=-7 (0xFFFFFFF9), b=2 -> q=-3 (0xFFFFFFFD), r=-1 (0xFFFFFFFF).
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0; DIVU a=5, b=0 -> q=0xFFFFFFFF, r=5, div_zero=1 when enabled.
REQ-033 start held high across whole run with changing a/b -> result reflects first operands; new division starts on done cycle, second done 33 cycles later.
REQ-034 rst asserted at cycle 10 of a run -> busy=0, done=0, q=r=0 next cycle; no done pulse follows.
